image_hfilter3: RTL and testbench
=================================

Name: image_hfilter3

Overview:
- Horizontal 3-tap smoothing stage with weights [1 2 1]/4, applied per RGB channel.
- Sits between image_read and image_write in the image-processing datapath.
- Consumes the two-pixels-per-clock stream (even pixel on *0 lanes, odd pixel on *1 lanes) qualified by hsync.
- Emits a filtered stream in the same format, plus a frame-done pulse.

Parameters:
WIDTH, 768, pixels per line; even and >= 4.
HEIGHT, 512, lines per frame.

Ports:
HCLK  in  1  clock, rising edge.
HRESET  in  1  asynchronous active-high reset.
hsync_in  in  1  input beat valid; one pixel pair per high cycle.
DATA_R0_IN, DATA_G0_IN, DATA_B0_IN  in  8 each  even pixel x=2k.
DATA_R1_IN, DATA_G1_IN, DATA_B1_IN  in  8 each  odd pixel x=2k+1.
hsync_out  out  1  output beat valid.
DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT  out  8 each  filtered even pixel.
DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT  out  8 each  filtered odd pixel.
frame_done  out  1  one-cycle pulse after the last pair of line HEIGHT-1 is emitted.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - beat_cnt=0, line_cnt=0; held registers 0.
  - Applies mid-line and mid-frame too: partial data is discarded, no flush.
- Filter, per channel:
  - y[x] = (p[x-1] + 2*p[x] + p[x+1] + 2) >> 2, 10-bit sum.
  - Result never exceeds 255; no saturation logic.
  - Edge replication: p[-1]=p[0], p[WIDTH]=p[WIDTH-1].
- Registers:
  - held pair H (6x8).
  - left neighbour L (3x8): pixel x=2k-1 relative to H.
  - beat_cnt, 0..WIDTH/2-1.
  - line_cnt, 0..HEIGHT-1.
- States:
  - IDLE:
    - hsync_in=1 -> H<=input, L<=input even pixel (replicate), beat_cnt<=1, go HOLD.
    - Otherwise stay.
  - HOLD:
    - hsync_in=0 -> stay, no output (gaps of any length allowed).
    - hsync_in=1 -> emit H filtered, with right neighbour of H.p1 = input even pixel.
    - Same cycle: L<=H.p1, H<=input.
    - If beat_cnt==WIDTH/2-1: go FLUSH, beat_cnt<=0. Else beat_cnt++.
  - FLUSH:
    - Emit H filtered, right neighbour = H.p1 (replicate).
    - line_cnt++. If line_cnt==HEIGHT-1: frame_done=1 with this output, line_cnt<=0.
    - hsync_in=1 in the same cycle (next line's first beat) -> accept it as IDLE does, go HOLD.
    - Otherwise go IDLE.
- Output timing:
  - All outputs registered; hsync_out high exactly one cycle per emitted pair.
  - Latency: pair k appears the cycle after pair k+1 is input.
  - The last pair of a line appears 2 cycles after its input.
  - Data outputs hold their last value when hsync_out=0.
- Input beats arriving in excess of WIDTH/2 per line are never lost; line boundaries come only from beat_cnt.

Test Plan:
- Reset, WIDTH=4, HEIGHT=2, constant 100 on all lanes, continuous hsync for 4 beats -> 4 output beats, all 100. Line-0 pairs appear at input cycles +1 and +2; frame_done is high with the 4th output beat only.
- WIDTH=4 ramp, R pixels 0,4,8,12 -> R out pairs (1,4) then (8,11); G and B identical when driven identically.
- WIDTH=4 impulse, R x=1 equals 255, others 0 -> R out (64,128),(64,0).
- Same ramp with 3 idle cycles between beats -> same values. hsync_out pulses 1 cycle after the 2nd beat; the flush pulse comes 2 cycles after it.
- Back-to-back lines: next line's first beat lands in the FLUSH cycle -> previous-line flush output is correct, and the new line's left edge uses replication (not the previous line's last pixel).
- Assert HRESET in HOLD mid-line -> outputs 0 immediately, no flush beat. A new line after release filters correctly from beat_cnt=0.

Source files
------------

// File: rtl/image_hfilter3.sv
// Horizontal [1 2 1]/4 smoothing of a two-pixels-per-clock RGB stream.
// One pixel pair is held back so that each pair can see its right-hand neighbour.
`timescale 1ns/1ps
module image_hfilter3 #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       hsync_in,
    input  logic [7:0] DATA_R0_IN,
    input  logic [7:0] DATA_G0_IN,
    input  logic [7:0] DATA_B0_IN,
    input  logic [7:0] DATA_R1_IN,
    input  logic [7:0] DATA_G1_IN,
    input  logic [7:0] DATA_B1_IN,
    output logic       hsync_out,
    output logic [7:0] DATA_R0_OUT,
    output logic [7:0] DATA_G0_OUT,
    output logic [7:0] DATA_B0_OUT,
    output logic [7:0] DATA_R1_OUT,
    output logic [7:0] DATA_G1_OUT,
    output logic [7:0] DATA_B1_OUT,
    output logic       frame_done
);
    localparam int PAIRS  = WIDTH / 2;
    localparam int BEAT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAIRS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // The 10-bit sum peaks at 1022, so the shifted result always fits in 8 bits.
    function automatic logic [7:0] tap3(input logic [7:0] l, input logic [7:0] c,
                                        input logic [7:0] r);
        logic [9:0] sum;
        sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'd2;
        return 8'(sum >> 2);
    endfunction

    function automatic rgb_t smooth(input rgb_t l, input rgb_t c, input rgb_t r);
        rgb_t y;
        y.r = tap3(l.r, c.r, r.r);
        y.g = tap3(l.g, c.g, r.g);
        y.b = tap3(l.b, c.b, r.b);
        return y;
    endfunction

    state_t             state;
    rgb_t               h0, h1, left, out0, out1;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [LINE_W-1:0]  line_cnt;

    rgb_t in0, in1, right, y0, y1;

    assign in0 = {DATA_R0_IN, DATA_G0_IN, DATA_B0_IN};
    assign in1 = {DATA_R1_IN, DATA_G1_IN, DATA_B1_IN};

    // At the end of a line the odd pixel stands in for its own missing right neighbour.
    assign right = (state == FLUSH) ? h1 : in0;
    assign y0    = smooth(left, h0, h1);
    assign y1    = smooth(h0, h1, right);

    assign DATA_R0_OUT = out0.r;
    assign DATA_G0_OUT = out0.g;
    assign DATA_B0_OUT = out0.b;
    assign DATA_R1_OUT = out1.r;
    assign DATA_G1_OUT = out1.g;
    assign DATA_B1_OUT = out1.b;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: the held pair is reset too, so a line cut short by reset leaves no stale pixels behind.
            state      <= IDLE;
            h0         <= '0;
            h1         <= '0;
            left       <= '0;
            out0       <= '0;
            out1       <= '0;
            beat_cnt   <= '0;
            line_cnt   <= '0;
            hsync_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; data outputs keep their value between beats.
            hsync_out  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hsync_in) begin
                        h0       <= in0;
                        h1       <= in1;
                        left     <= in0;
                        beat_cnt <= BEAT_W'(1);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hsync_in) begin
                        hsync_out <= 1'b1;
                        out0      <= y0;
                        out1      <= y1;
                        left      <= h1;
                        h0        <= in0;
                        h1        <= in1;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= FLUSH;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    hsync_out <= 1'b1;
                    out0      <= y0;
                    out1      <= y1;
                    if (line_cnt == LAST_LINE) begin
                        frame_done <= 1'b1;
                        line_cnt   <= '0;
                    end else begin
                        line_cnt <= line_cnt + LINE_W'(1);
                    end
                    // A beat arriving now opens the next line, with fresh left-edge replication.
                    if (hsync_in) begin
                        h0       <= in0;
                        h1       <= in1;
                        left     <= in0;
                        beat_cnt <= BEAT_W'(1);
                        state    <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_hfilter3.sv
// Bench for image_hfilter3: randomized lines scored against a per-pixel [1 2 1]/4 model
// with edge replication, plus directed ramp, impulse, gap, back-to-back and reset scenarios.
`timescale 1ns/1ps
module tb_image_hfilter3;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int PAIRS  = WIDTH / 2;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       hsync_in = 1'b0;
    logic [7:0] DATA_R0_IN = '0, DATA_G0_IN = '0, DATA_B0_IN = '0;
    logic [7:0] DATA_R1_IN = '0, DATA_G1_IN = '0, DATA_B1_IN = '0;
    logic       hsync_out, frame_done;
    logic [7:0] DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT;
    logic [7:0] DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT;

    typedef struct {
        logic [7:0] r0, g0, b0, r1, g1, b1;
        logic       fd;
        int         cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    pix[3][WIDTH];
    int    cyc = 0;
    int    line_no = 0;
    int    checks = 0;
    int    errors = 0;

    image_hfilter3 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .hsync_in(hsync_in),
        .DATA_R0_IN(DATA_R0_IN), .DATA_G0_IN(DATA_G0_IN), .DATA_B0_IN(DATA_B0_IN),
        .DATA_R1_IN(DATA_R1_IN), .DATA_G1_IN(DATA_G1_IN), .DATA_B1_IN(DATA_B1_IN),
        .hsync_out(hsync_out),
        .DATA_R0_OUT(DATA_R0_OUT), .DATA_G0_OUT(DATA_G0_OUT), .DATA_B0_OUT(DATA_B0_OUT),
        .DATA_R1_OUT(DATA_R1_OUT), .DATA_G1_OUT(DATA_G1_OUT), .DATA_B1_OUT(DATA_B1_OUT),
        .frame_done(frame_done)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [47:0] dout();
        return {DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT};
    endfunction

    // Reference filter: straight from the pixel formula with replicated line edges.
    function automatic int yv(input int ch, input int x);
        int l, r;
        l = pix[ch][(x == 0) ? 0 : x - 1];
        r = pix[ch][(x == WIDTH - 1) ? WIDTH - 1 : x + 1];
        return (l + 2 * pix[ch][x] + r + 2) / 4;
    endfunction

    function automatic beat_t mk_exp(input int k, input logic fd, input int c);
        beat_t e;
        e.r0 = 8'(yv(0, 2 * k));     e.g0 = 8'(yv(1, 2 * k));     e.b0 = 8'(yv(2, 2 * k));
        e.r1 = 8'(yv(0, 2 * k + 1)); e.g1 = 8'(yv(1, 2 * k + 1)); e.b1 = 8'(yv(2, 2 * k + 1));
        e.fd  = fd;
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard: every emitted beat is matched in order against the model.
    always @(negedge HCLK) begin
        beat_t o, e;
        if (!HRESET) begin
            if (frame_done !== 1'b0 && hsync_out !== 1'b1) begin
                errors++;
                $display("FAIL stray_frame_done at cycle %0d: got frame_done=%b hsync_out=%b, required frame_done only with a beat",
                         cyc, frame_done, hsync_out);
            end
            if (hsync_out === 1'b1) begin
                o.r0 = DATA_R0_OUT; o.g0 = DATA_G0_OUT; o.b0 = DATA_B0_OUT;
                o.r1 = DATA_R1_OUT; o.g1 = DATA_G1_OUT; o.b1 = DATA_B1_OUT;
                o.fd = frame_done;  o.cyc = cyc;
                obs_q.push_back(o);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat at cycle %0d: got %h, required no beat", cyc, dout());
                end else begin
                    e = exp_q.pop_front();
                    if ({o.r0, o.g0, o.b0, o.r1, o.g1, o.b1} !== {e.r0, e.g0, e.b0, e.r1, e.g1, e.b1}) begin
                        errors++;
                        $display("FAIL beat_data at cycle %0d: got %h, required %h", cyc,
                                 {o.r0, o.g0, o.b0, o.r1, o.g1, o.b1}, {e.r0, e.g0, e.b0, e.r1, e.g1, e.b1});
                    end
                    checks++;
                    if (o.fd !== e.fd) begin
                        errors++;
                        $display("FAIL beat_frame_done at cycle %0d: got %b, required %b", cyc, o.fd, e.fd);
                    end
                    checks++;
                    if (o.cyc != e.cyc) begin
                        errors++;
                        $display("FAIL beat_timing: beat seen at cycle %0d, required cycle %0d", o.cyc, e.cyc);
                    end
                end
            end
        end
    end

    // One clock of stimulus: a pixel pair from pix[] when valid, junk otherwise.
    task automatic put(input bit v, input int k);
        @(posedge HCLK); #1;
        hsync_in = v;
        if (v) begin
            DATA_R0_IN = 8'(pix[0][2 * k]);     DATA_G0_IN = 8'(pix[1][2 * k]);
            DATA_B0_IN = 8'(pix[2][2 * k]);     DATA_R1_IN = 8'(pix[0][2 * k + 1]);
            DATA_G1_IN = 8'(pix[1][2 * k + 1]); DATA_B1_IN = 8'(pix[2][2 * k + 1]);
        end else begin
            DATA_R0_IN = 8'($urandom); DATA_G0_IN = 8'($urandom); DATA_B0_IN = 8'($urandom);
            DATA_R1_IN = 8'($urandom); DATA_G1_IN = 8'($urandom); DATA_B1_IN = 8'($urandom);
        end
    endtask

    // Drives one line; gap < 0 picks a random 0..3 idle cycles before each later beat.
    task automatic send_line(input int lead, input int gap);
        int c;
        c = 0;
        repeat (lead) put(1'b0, 0);
        for (int k = 0; k < PAIRS; k++) begin
            if (k > 0) repeat ((gap < 0) ? int'($urandom_range(3, 0)) : gap) put(1'b0, 0);
            put(1'b1, k);
            c = cyc;
            if (k > 0) exp_q.push_back(mk_exp(k - 1, 1'b0, c + 1));
        end
        exp_q.push_back(mk_exp(PAIRS - 1, (line_no % HEIGHT) == HEIGHT - 1, c + 2));
        line_no++;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) put(1'b0, 0);
        repeat (3) put(1'b0, 0);
    endtask

    task automatic set_const(input int v);
        for (int ch = 0; ch < 3; ch++) for (int x = 0; x < WIDTH; x++) pix[ch][x] = v;
    endtask

    task automatic set_random();
        for (int ch = 0; ch < 3; ch++) for (int x = 0; x < WIDTH; x++) pix[ch][x] = int'($urandom_range(255, 0));
    endtask

    task automatic set_ramp();
        for (int ch = 0; ch < 3; ch++) for (int x = 0; x < WIDTH; x++) pix[ch][x] = 4 * x;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        hsync_in = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        checks++;
        if ({hsync_out, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got hsync_out/frame_done=%b, required 00", {hsync_out, frame_done});
        end
        checks++;
        if (dout() !== 48'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", dout());
        end
        hsync_in = 1'b0;
        HRESET = 1'b0;
        line_no = 0;
        obs_q.delete();
        repeat (3) put(1'b0, 0);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_beats: got %0d beats, required 0", obs_q.size());
        end
    endtask

    task automatic test_constant();
        set_const(100);
        obs_q.delete();
        send_line(0, 0);
        send_line(0, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_constant: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL constant_beat_count: got %0d, required 4", obs_q.size());
        end
        checks++;
        if (dout() !== {6{8'd100}}) begin
            errors++;
            $display("FAIL constant_hold: got %h, required all 64", dout());
        end
    endtask

    task automatic test_ramp();
        set_ramp();
        obs_q.delete();
        send_line(2, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_ramp: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() < 2) begin
            errors++;
            $display("FAIL ramp_beats: got %0d beats, required 2", obs_q.size());
        end else begin
            if ({obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1} !== {8'd1, 8'd4, 8'd8, 8'd11}) begin
                errors++;
                $display("FAIL ramp_red: got %0d,%0d,%0d,%0d, required 1,4,8,11",
                         obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1);
            end
            checks++;
            if ({obs_q[0].g0, obs_q[0].b1, obs_q[1].g1, obs_q[1].b0} !== {8'd1, 8'd4, 8'd11, 8'd8}) begin
                errors++;
                $display("FAIL ramp_gb: got %0d,%0d,%0d,%0d, required 1,4,11,8",
                         obs_q[0].g0, obs_q[0].b1, obs_q[1].g1, obs_q[1].b0);
            end
        end
    endtask

    task automatic test_impulse();
        set_const(0);
        pix[0][1] = 255;
        obs_q.delete();
        send_line(1, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_impulse: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() < 2) begin
            errors++;
            $display("FAIL impulse_beats: got %0d beats, required 2", obs_q.size());
        end else if ({obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1, obs_q[0].g1, obs_q[1].b0}
                     !== {8'd64, 8'd128, 8'd64, 8'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL impulse_values: got R %0d,%0d,%0d,%0d G1 %0d B0 %0d, required R 64,128,64,0 G1 0 B0 0",
                     obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1, obs_q[0].g1, obs_q[1].b0);
        end
    endtask

    task automatic test_gaps();
        set_ramp();
        obs_q.delete();
        send_line(3, 3);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_gaps: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() < 2) begin
            errors++;
            $display("FAIL gaps_beats: got %0d beats, required 2", obs_q.size());
        end else begin
            if (obs_q[1].cyc - obs_q[0].cyc != 1) begin
                errors++;
                $display("FAIL gaps_flush_spacing: got %0d cycles between beats, required 1",
                         obs_q[1].cyc - obs_q[0].cyc);
            end
            checks++;
            if ({obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1} !== {8'd1, 8'd4, 8'd8, 8'd11}) begin
                errors++;
                $display("FAIL gaps_red: got %0d,%0d,%0d,%0d, required 1,4,8,11",
                         obs_q[0].r0, obs_q[0].r1, obs_q[1].r0, obs_q[1].r1);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        set_random();
        pix[0][WIDTH - 1] = 255;
        send_line(0, 0);
        set_random();
        pix[0][0] = 0;
        pix[0][1] = 0;
        send_line(0, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_back_to_back: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL back_to_back_beats: got %0d, required 4", obs_q.size());
        end else if (obs_q[2].r0 !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back_left_edge: got %0d, required 0", obs_q[2].r0);
        end
    endtask

    task automatic test_random();
        obs_q.delete();
        for (int n = 0; n < 8; n++) begin
            set_random();
            send_line(int'($urandom_range(2, 0)), -1);
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_random: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() != 8 * PAIRS) begin
            errors++;
            $display("FAIL random_beat_count: got %0d, required %0d", obs_q.size(), 8 * PAIRS);
        end
    endtask

    task automatic test_mid_reset();
        set_const(200);
        send_line(0, 0);
        for (int i = 0; i < HEIGHT && (line_no % HEIGHT) != 1; i++) send_line(0, 0);
        wait_drain();
        exp_q.delete();
        set_random();
        put(1'b1, 0);
        put(1'b0, 0);
        @(negedge HCLK); #2;
        HRESET = 1'b1;
        #1;
        checks++;
        if ({hsync_out, frame_done, dout()} !== 50'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags %b data %h, required all 0",
                     {hsync_out, frame_done}, dout());
        end
        exp_q.delete();
        obs_q.delete();
        line_no = 0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        repeat (4) put(1'b0, 0);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_no_flush: got %0d beats, required 0", obs_q.size());
        end
        set_random();
        send_line(0, 0);
        set_random();
        send_line(1, -1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_mid_reset: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (obs_q.size() != 2 * PAIRS) begin
            errors++;
            $display("FAIL mid_reset_beat_count: got %0d, required %0d", obs_q.size(), 2 * PAIRS);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_impulse();
        test_gaps();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
